// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus: two writeback requesters, the register-file write
// port, the issue-stage reservation, the operand hazard/bypass query and the
// scoreboard. The slave modport is the arbiter side; the master modport is the
// pipeline side that drives requests and consumes results.
// last_grant is a debug view of the round-robin pointer (0 = ALU, 1 = LSU).
interface regfile_wb_arbiter_if;
  logic        alu_valid_i;
  logic [4:0]  alu_addr_i;
  logic [31:0] alu_data_i;
  logic        alu_ready_o;

  logic        lsu_valid_i;
  logic [4:0]  lsu_addr_i;
  logic [31:0] lsu_data_i;
  logic        lsu_ready_o;

  logic        rf_write_enable_o;
  logic [4:0]  rf_write_addr_o;
  logic [31:0] rf_write_data_o;

  logic        issue_valid_i;
  logic [4:0]  issue_rd_i;

  logic [4:0]  rs_a_i;
  logic [4:0]  rs_b_i;
  logic        hazard_a_o;
  logic        hazard_b_o;
  logic        fwd_valid_a_o;
  logic        fwd_valid_b_o;
  logic [31:0] fwd_data_a_o;
  logic [31:0] fwd_data_b_o;

  logic [31:0] busy_o;
  logic        last_grant;

  modport slave (
    input  alu_valid_i, alu_addr_i, alu_data_i,
    output alu_ready_o,
    input  lsu_valid_i, lsu_addr_i, lsu_data_i,
    output lsu_ready_o,
    output rf_write_enable_o, rf_write_addr_o, rf_write_data_o,
    input  issue_valid_i, issue_rd_i,
    input  rs_a_i, rs_b_i,
    output hazard_a_o, hazard_b_o,
    output fwd_valid_a_o, fwd_valid_b_o, fwd_data_a_o, fwd_data_b_o,
    output busy_o, last_grant
  );

  modport master (
    output alu_valid_i, alu_addr_i, alu_data_i,
    input  alu_ready_o,
    output lsu_valid_i, lsu_addr_i, lsu_data_i,
    input  lsu_ready_o,
    input  rf_write_enable_o, rf_write_addr_o, rf_write_data_o,
    output issue_valid_i, issue_rd_i,
    output rs_a_i, rs_b_i,
    input  hazard_a_o, hazard_b_o,
    input  fwd_valid_a_o, fwd_valid_b_o, fwd_data_a_o, fwd_data_b_o,
    input  busy_o, last_grant
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with destination scoreboard.
// Two requesters (ALU = 0, LSU = 1) share one register-file write port.
// Handshake: a requester transfers on a rising edge where its valid and ready
// are both high; ready is combinational, asserts only while its own valid is
// high, at most one ready is high per cycle, and both are low during reset.
// The winner's addr/data are registered and appear on rf_write_* one cycle
// after the transfer. Writes to x0 are accepted but never enabled.
// Optional feature macro: REGFILE_WB_BYPASS_EN forwards the data currently on
// the write port to matching operand queries and masks their hazard.
module regfile_wb_arbiter (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  regfile_wb_arbiter_if.slave  bus
);

  logic        last_q;
  logic        we_q;
  logic [4:0]  waddr_q;
  logic [31:0] wdata_q;
  logic [31:0] busy_q;

  logic        alu_rdy;
  logic        lsu_rdy;
  logic        xfer;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;
  logic [31:0] busy_next;
  logic        byp_a;
  logic        byp_b;

  // Round-robin grant: with both valid, serve the requester not granted last.
  always_comb begin
    alu_rdy  = reset_ni & bus.alu_valid_i & (~bus.lsu_valid_i | last_q);
    lsu_rdy  = reset_ni & bus.lsu_valid_i & (~bus.alu_valid_i | ~last_q);
    xfer     = alu_rdy | lsu_rdy;
    sel_addr = alu_rdy ? bus.alu_addr_i : bus.lsu_addr_i;
    sel_data = alu_rdy ? bus.alu_data_i : bus.lsu_data_i;
  end

  // Scoreboard next state: clear on the visible write, then set on reservation
  // so a same-cycle reservation of the same register wins.
  always_comb begin
    busy_next = busy_q;
    if (we_q) busy_next[waddr_q] = 1'b0;
    if (bus.issue_valid_i && (bus.issue_rd_i != 5'd0)) busy_next[bus.issue_rd_i] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Registered write port, grant pointer and scoreboard.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
      busy_q  <= 32'd0;
    end else begin
      busy_q <= busy_next;
      we_q   <= 1'b0;
      if (xfer) begin
        last_q <= lsu_rdy;
        // x0 writes complete the handshake but leave the port untouched.
        if (sel_addr != 5'd0) begin
          we_q    <= 1'b1;
          waddr_q <= sel_addr;
          wdata_q <= sel_data;
        end
      end
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  // Forward the in-flight write to matching non-zero operands.
  always_comb begin
    byp_a = we_q && (waddr_q == bus.rs_a_i) && (bus.rs_a_i != 5'd0);
    byp_b = we_q && (waddr_q == bus.rs_b_i) && (bus.rs_b_i != 5'd0);
  end
  assign bus.fwd_data_a_o = byp_a ? wdata_q : 32'd0;
  assign bus.fwd_data_b_o = byp_b ? wdata_q : 32'd0;
`else
  // No bypass path: hazards come straight from the scoreboard.
  always_comb begin
    byp_a = 1'b0;
    byp_b = 1'b0;
  end
  assign bus.fwd_data_a_o = 32'd0;
  assign bus.fwd_data_b_o = 32'd0;
`endif

  assign bus.fwd_valid_a_o     = byp_a;
  assign bus.fwd_valid_b_o     = byp_b;
  assign bus.hazard_a_o        = (bus.rs_a_i != 5'd0) & busy_q[bus.rs_a_i] & ~byp_a;
  assign bus.hazard_b_o        = (bus.rs_b_i != 5'd0) & busy_q[bus.rs_b_i] & ~byp_b;
  assign bus.alu_ready_o       = alu_rdy;
  assign bus.lsu_ready_o       = lsu_rdy;
  assign bus.rf_write_enable_o = we_q;
  assign bus.rf_write_addr_o   = waddr_q;
  assign bus.rf_write_data_o   = wdata_q;
  assign bus.busy_o            = busy_q;
  assign bus.last_grant        = last_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a vector table of per-cycle requests with
// hand-derived ready expectations, a write queue holding the expected
// register-file writes, a small scoreboard model for busy/hazard/bypass, and
// hand-written reset sequences.
module tb_regfile_wb_arbiter;

  logic clk_i = 1'b0;
  logic reset_ni;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .bus      (bus)
  );

  // Clock and reset
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        ea;
    logic        el;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [36:0] exp_q[$];
  logic [31:0] m_busy;
  logic        m_last;

  vec_t vecs[17];

  function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                              input logic lv, input logic [4:0] la, input logic [31:0] ld,
                              input logic iv, input logic [4:0] ird,
                              input logic [4:0] ra, input logic [4:0] rb,
                              input logic ea, input logic el);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad;
    v.lv = lv; v.la = la; v.ld = ld;
    v.iv = iv; v.ird = ird; v.ra = ra; v.rb = rb;
    v.ea = ea; v.el = el;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.alu_valid_i   = v.av;
    bus.alu_addr_i    = v.aa;
    bus.alu_data_i    = v.ad;
    bus.lsu_valid_i   = v.lv;
    bus.lsu_addr_i    = v.la;
    bus.lsu_data_i    = v.ld;
    bus.issue_valid_i = v.iv;
    bus.issue_rd_i    = v.ird;
    bus.rs_a_i        = v.ra;
    bus.rs_b_i        = v.rb;
  endtask

  function automatic vec_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // One cycle: drive, check combinational and registered outputs, advance model.
  task automatic step(input vec_t v);
    logic        have_wr;
    logic [36:0] e;
    logic        ba, bb, ha, hb;
    @(negedge clk_i);
    drive(v);
    #1;
    chk("alu_ready", {31'd0, bus.alu_ready_o}, {31'd0, v.ea});
    chk("lsu_ready", {31'd0, bus.lsu_ready_o}, {31'd0, v.el});
    have_wr = (exp_q.size() != 0);
    e = 37'd0;
    if (have_wr) begin
      e = exp_q.pop_front();
      chk("wr_en", {31'd0, bus.rf_write_enable_o}, 32'd1);
      chk("wr_addr", {27'd0, bus.rf_write_addr_o}, {27'd0, e[36:32]});
      chk("wr_data", bus.rf_write_data_o, e[31:0]);
    end else begin
      chk("wr_en", {31'd0, bus.rf_write_enable_o}, 32'd0);
    end
    chk("busy", bus.busy_o, m_busy);
    chk("last_grant", {31'd0, bus.last_grant}, {31'd0, m_last});
`ifdef REGFILE_WB_BYPASS_EN
    ba = have_wr && (e[36:32] == v.ra) && (v.ra != 5'd0);
    bb = have_wr && (e[36:32] == v.rb) && (v.rb != 5'd0);
`else
    ba = 1'b0;
    bb = 1'b0;
`endif
    ha = (v.ra != 5'd0) && m_busy[v.ra] && !ba;
    hb = (v.rb != 5'd0) && m_busy[v.rb] && !bb;
    chk("hazard_a", {31'd0, bus.hazard_a_o}, {31'd0, ha});
    chk("hazard_b", {31'd0, bus.hazard_b_o}, {31'd0, hb});
    chk("fwd_valid_a", {31'd0, bus.fwd_valid_a_o}, {31'd0, ba});
    chk("fwd_valid_b", {31'd0, bus.fwd_valid_b_o}, {31'd0, bb});
    chk("fwd_data_a", bus.fwd_data_a_o, ba ? e[31:0] : 32'd0);
    chk("fwd_data_b", bus.fwd_data_b_o, bb ? e[31:0] : 32'd0);
    // Model update for the coming edge
    if (have_wr) m_busy[e[36:32]] = 1'b0;
    if (v.iv && v.ird != 5'd0) m_busy[v.ird] = 1'b1;
    if (v.ea) begin
      m_last = 1'b0;
      if (v.aa != 5'd0) exp_q.push_back({v.aa, v.ad});
    end
    if (v.el) begin
      m_last = 1'b1;
      if (v.la != 5'd0) exp_q.push_back({v.la, v.ld});
    end
  endtask

  // Checks the state forced by a reset edge, with requests held high.
  task automatic check_reset_state(input string tag);
    chk({tag, "_wr_en"}, {31'd0, bus.rf_write_enable_o}, 32'd0);
    chk({tag, "_wr_addr"}, {27'd0, bus.rf_write_addr_o}, 32'd0);
    chk({tag, "_wr_data"}, bus.rf_write_data_o, 32'd0);
    chk({tag, "_busy"}, bus.busy_o, 32'd0);
    chk({tag, "_last_grant"}, {31'd0, bus.last_grant}, 32'd1);
    chk({tag, "_alu_ready"}, {31'd0, bus.alu_ready_o}, 32'd0);
    chk({tag, "_lsu_ready"}, {31'd0, bus.lsu_ready_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] r0, r1, r2;
    r0 = $urandom;
    r1 = $urandom;
    r2 = $urandom_range(32'hFFFF, 1);

    // Both valid from reset: ALU, LSU, ALU, LSU
    vecs[0]  = mk(1, 1, 32'h1111_1111, 1, 2, 32'h2222_2222, 0, 0, 0, 0, 1, 0);
    vecs[1]  = mk(1, 1, 32'h1111_1111, 1, 2, 32'h2222_2222, 0, 0, 0, 0, 0, 1);
    vecs[2]  = mk(1, 1, 32'h3333_3333, 1, 2, 32'h4444_4444, 0, 0, 0, 0, 1, 0);
    vecs[3]  = mk(1, 1, 32'h3333_3333, 1, 2, 32'h4444_4444, 0, 0, 0, 0, 0, 1);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
    // Reserve x5, ALU writes it, busy clears afterwards
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
    vecs[6]  = mk(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 5, 0, 1, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 5, 0, 0);
    // LSU write to x0: handshake only
    vecs[9]  = mk(0, 0, 0, 1, 0, 32'h0000_1234, 0, 0, 0, 0, 0, 1);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // x7: reserve, write, re-reserve during the write cycle, bypass query
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
    vecs[12] = mk(1, 7, 32'hA5A5_A5A5, 0, 0, 0, 0, 0, 7, 0, 1, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 1, 7, 7, 7, 0, 0);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0);
    // Last grant was ALU: contention goes to LSU, then a lone ALU request
    vecs[15] = mk(1, 9, r0, 1, 10, r1, 1, 0, 0, 0, 0, 1);
    vecs[16] = mk(1, 11, r2, 0, 0, 0, 0, 0, 10, 9, 1, 0);

    reset_ni = 1'b0;
    drive(idle());
    m_busy = 32'd0;
    m_last = 1'b1;
    repeat (2) @(negedge clk_i);
    bus.alu_valid_i = 1'b1;
    bus.lsu_valid_i = 1'b1;
    #1;
    check_reset_state("reset");
    @(negedge clk_i);
    drive(idle());
    reset_ni = 1'b1;

    for (int i = 0; i < 17; i++) step(vecs[i]);
    step(idle());
    step(idle());

    // Reset while a write is pending and x3 is reserved
    step(mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0));
    step(mk(1, 3, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    @(negedge clk_i);
    reset_ni = 1'b0;
    bus.alu_valid_i   = 1'b1;
    bus.lsu_valid_i   = 1'b1;
    bus.issue_valid_i = 1'b1;
    bus.issue_rd_i    = 5'd4;
    #1;
    chk("rst_mid_alu_ready", {31'd0, bus.alu_ready_o}, 32'd0);
    chk("rst_mid_lsu_ready", {31'd0, bus.lsu_ready_o}, 32'd0);
    exp_q.delete();
    @(negedge clk_i);
    #1;
    check_reset_state("rst_mid");
    @(negedge clk_i);
    drive(idle());
    reset_ni = 1'b1;
    m_busy = 32'd0;
    m_last = 1'b1;
    step(idle());
    // x0 reservation is ignored; both valid after reset goes to ALU
    step(mk(1, 6, 32'h0BAD_CAFE, 1, 8, 32'h600D_F00D, 1, 0, 0, 0, 1, 0));
    step(idle());
    step(idle());

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have ports: clk_i  input  1  single clock, all state on rising edge.
REQ-002 SHALL have: reset_ni  input  1  reset, synchronous, active-low.
REQ-003 SHALL have: alu_valid_i in 1, alu_addr_i in 5, alu_data_i in 32, alu_ready_o out 1; ALU writeback request, requester 0.
REQ-004 SHALL have: lsu_valid_i in 1, lsu_addr_i in 5, lsu_data_i in 32, lsu_ready_o out 1; load-unit writeback request, requester 1.
REQ-005 SHALL have: rf_write_enable_o out 1, rf_write_addr_o out 5, rf_write_data_o out 32; register-file write port.
REQ-006 SHALL have: issue_valid_i in 1, issue_rd_i in 5; destination reservation from issue stage.
REQ-007 SHALL have: rs_a_i in 5, rs_b_i in 5, hazard_a_o out 1, hazard_b_o out 1; operand hazard query.
REQ-008 SHALL have: fwd_valid_a_o, fwd_valid_b_o out 1; fwd_data_a_o, fwd_data_b_o out 32; bypass outputs.
REQ-009 SHALL have: busy_o out 32; scoreboard, bit 0 constant 0.

Function
REQ-010 Transfer on requester SHALL occur when valid_i and ready_o are high at the same rising edge.
REQ-011 ready_o SHALL be combinational: at most one of alu_ready_o/lsu_ready_o high per cycle; a ready SHALL assert only while its valid is high.
REQ-012 Single requester valid: that requester SHALL be granted.
REQ-013 Both valid: round-robin; pointer last_grant (reset = 1, LSU) selects the other requester; last_grant SHALL update only on a transfer.
REQ-014 Granted addr/data SHALL be registered; rf_write_* SHALL present them the cycle after transfer (latency 1); rf_write_enable_o high exactly one cycle per transfer.
REQ-015 Transfer with addr 0 SHALL complete (ready high) but SHALL drive rf_write_enable_o = 0, no scoreboard effect.
REQ-016 Idle cycle: rf_write_enable_o = 0; rf_write_addr_o/rf_write_data_o hold last values.
REQ-017 Scoreboard: issue_valid_i with issue_rd_i != 0 SHALL set busy_o[issue_rd_i] at the next edge; rd 0 ignored.
REQ-018 Cycle with rf_write_enable_o = 1 SHALL clear busy_o[rf_write_addr_o] at the next edge.
REQ-019 Set and clear of the same bit in one cycle: set SHALL win (new reservation).
REQ-020 Reservation of an already-busy register SHALL leave it busy (no count, single outstanding write per register).
REQ-021 hazard_a_o SHALL be combinational = busy_o[rs_a_i] unless bypassed per REQ-027; same for b; rs 0 never hazards.
REQ-022 Writeback to a non-busy register SHALL still be written; busy unaffected except REQ-018 (clear of 0 bit is no-op).

Reset
REQ-023 reset_ni low at a rising edge SHALL force: busy_o = 0, rf_write_enable_o = 0, rf_write_addr_o = 0, rf_write_data_o = 0, last_grant = 1.
REQ-024 During reset cycles ready outputs SHALL be 0; no transfer, no reservation accepted.
REQ-025 Reset mid-operation SHALL drop the registered pending write (no write-enable pulse after reset) and all reservations.
REQ-026 Combinational outputs SHALL read 0 while busy_o = 0 and rf_write_enable_o = 0 (fwd_* = 0, hazard_* = 0).

Configuration
REQ-027 Macro REGFILE_WB_BYPASS_EN defined: when rf_write_enable_o = 1 and rf_write_addr_o == rs_a_i != 0, fwd_valid_a_o = 1, fwd_data_a_o = rf_write_data_o, hazard_a_o = 0; same for b.
REQ-028 Macro undefined: fwd_valid_* = 0, fwd_data_* = 0 constantly; hazard_* = busy bit only; ports remain present.

Verification
REQ-029 Reset, then issue rd=5, next cycle alu writes addr 5 data 0xDEADBEEF -> busy_o[5] 1 for two cycles, rf_write_enable_o pulse one cycle after transfer with addr 5/data 0xDEADBEEF, busy_o[5] 0 the cycle after.
REQ-030 Both valid continuously 4 cycles, addrs 1 (alu) / 2 (lsu) -> grants ALU, LSU, ALU, LSU; rf_write_addr_o sequence 1,2,1,2.
REQ-031 lsu writes addr 0 data 0x1234 -> lsu_ready_o 1, rf_write_enable_o stays 0, busy_o unchanged.
REQ-032 busy_o[7]=1, writeback to 7 on output stage while issue rd=7 same cycle -> busy_o[7] remains 1.
REQ-033 rs_a_i=7 during write-enable cycle for addr 7, data 0xA5A5A5A5 -> with REGFILE_WB_BYPASS_EN fwd_valid_a_o 1, fwd_data_a_o 0xA5A5A5A5, hazard_a_o 0; without, hazard_a_o 1, fwd 0.
REQ-034 busy_o[3]=1 and ALU transfer accepted, reset_ni low next edge -> no write-enable pulse, busy_o = 0, last_grant = LSU.
